jelly_data_unpacker: RTL and testbench

Stream serializer sitting directly downstream of a pipeline insert FF stage: it takes one wide word of up to NUM units per valid/ready handshake and emits the units one per cycle, lowest unit first, on a narrow valid/ready port. It supports partial words via a per-word unit count and carries a packet-end flag through to the final emitted unit. Output is fully registered. Throughput is one unit per cycle, with no bubble between consecutive words.

---
 rtl/jelly_data_unpacker.sv | 88 ++++++++
 tb/tb_jelly_data_unpacker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_data_unpacker.sv
// Wide-to-narrow stream serializer: one NUM-unit word in, units out lowest first.
// Registered output, partial words via s_num, packet-end flag on the final unit.
//
// state | meaning
// EMPTY | reg_valid=0, no word held, s_ready=1
// HOLD  | reg_valid=1, emitting unit reg_idx of reg_data
module jelly_data_unpacker #(
    parameter int                    UNIT_WIDTH = 8,
    parameter int                    NUM        = 4,
    parameter int                    NUM_WIDTH  = $clog2(NUM + 1),
    parameter logic [UNIT_WIDTH-1:0] INIT_DATA  = {UNIT_WIDTH{1'bx}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cke,

    input  logic [NUM*UNIT_WIDTH-1:0] s_data,
    input  logic [NUM_WIDTH-1:0]      s_num,
    input  logic                      s_last,
    input  logic                      s_valid,
    output logic                      s_ready,

    output logic [UNIT_WIDTH-1:0]     m_data,
    output logic                      m_first,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready,

    output logic                      busy
);

    localparam int IDX_WIDTH = (NUM > 1) ? $clog2(NUM) : 1;

    logic [NUM-1:0][UNIT_WIDTH-1:0] reg_data;
    logic [NUM_WIDTH-1:0]           reg_num;
    logic                           reg_last;
    logic [IDX_WIDTH-1:0]           reg_idx;
    logic                           reg_valid;

    logic [NUM_WIDTH-1:0]           eff_num;
    logic                           end_unit;
    logic                           in_xfer;
    logic                           out_xfer;

    // Out-of-range counts (0 or above NUM) are treated as a full word.
    always_comb begin
        eff_num = s_num;
        if (s_num == '0 || s_num > NUM_WIDTH'(NUM)) begin
            eff_num = NUM_WIDTH'(NUM);
        end
    end

    assign end_unit = reg_valid && (NUM_WIDTH'(reg_idx) == reg_num - NUM_WIDTH'(1));
    assign s_ready  = !reg_valid || (m_ready && end_unit);
    assign in_xfer  = cke && s_valid && s_ready;
    assign out_xfer = cke && reg_valid && m_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_data  <= {NUM{INIT_DATA}};
            reg_num   <= NUM_WIDTH'(NUM);
            reg_last  <= 1'b0;
            reg_idx   <= '0;
            reg_valid <= 1'b0;
        end else if (in_xfer) begin
            // Load wins over the end-unit drain so consecutive words have no bubble.
            reg_data  <= s_data;
            reg_num   <= eff_num;
            reg_last  <= s_last;
            reg_idx   <= '0;
            reg_valid <= 1'b1;
        end else if (out_xfer) begin
            if (end_unit) begin
                reg_valid <= 1'b0;
                reg_idx   <= '0;
            end else begin
                reg_idx   <= reg_idx + IDX_WIDTH'(1);
            end
        end
    end

    assign m_data  = reg_data[reg_idx];
    assign m_first = (reg_idx == '0);
    assign m_last  = reg_last && end_unit;
    assign m_valid = reg_valid;
    assign busy    = reg_valid;

endmodule

// File: tb/tb_jelly_data_unpacker.sv
// Self-checking bench for jelly_data_unpacker: directed scenarios plus random
// backpressure, checked against a queue of expected output units.
module tb_jelly_data_unpacker;

    localparam int              UW   = 8;
    localparam int              N    = 4;
    localparam int              NW   = $clog2(N + 1);
    localparam logic [UW-1:0]   INIT = 8'h5A;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cke;
    logic [N*UW-1:0]   s_data;
    logic [NW-1:0]     s_num;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [UW-1:0]     m_data;
    logic              m_first;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic              busy;

    jelly_data_unpacker #(
        .UNIT_WIDTH (UW),
        .NUM        (N),
        .NUM_WIDTH  (NW),
        .INIT_DATA  (INIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .s_data  (s_data),
        .s_num   (s_num),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_first (m_first),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [UW-1:0] d;
        logic          f;
        logic          l;
    } unit_t;

    unit_t q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    function automatic void push_word(logic [N*UW-1:0] d, logic [NW-1:0] n, logic l);
        int eff;
        eff = (n == 0 || int'(n) > N) ? N : int'(n);
        for (int k = 0; k < eff; k++) begin
            unit_t u;
            u.d = d[k*UW +: UW];
            u.f = (k == 0);
            u.l = l && (k == eff - 1);
            q.push_back(u);
        end
    endfunction

    function automatic logic exp_ready();
        return (q.size() == 0) || (m_ready && q.size() == 1);
    endfunction

    // Moves the reference model across one rising edge using the currently driven inputs.
    task automatic advance();
        logic in_x, out_x;
        in_x  = reset_n && cke && s_valid && exp_ready();
        out_x = reset_n && cke && m_ready && (q.size() != 0);
        @(posedge clk);
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) push_word(s_data, s_num, s_last);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cke = 1'b0; s_valid = 1'b0; s_data = '0; s_num = '0;
        s_last = 1'b0; m_ready = 1'b0;
        advance(); advance();
        reset_n = 1'b1; cke = 1'b1;
        #1;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (m_first !== 1'b1) $display("FAIL reset_m_first got=%b exp=1", m_first); else pass_cnt++;
        total_cnt++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%b exp=0", m_last); else pass_cnt++;
        total_cnt++; if (m_data !== INIT) $display("FAIL reset_m_data got=%h exp=%h", m_data, INIT); else pass_cnt++;
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%b exp=1", s_ready); else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic [UW-1:0] exp_d;
        m_ready = 1'b1;
        s_data = 32'h44332211; s_num = 3'd4; s_last = 1'b1; s_valid = 1'b1;
        advance();
        s_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_d = UW'(8'h11 * (i + 1));
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL single_valid[%0d] got=%b exp=1", i, m_valid); else pass_cnt++;
            total_cnt++; if (m_data !== exp_d) $display("FAIL single_data[%0d] got=%h exp=%h", i, m_data, exp_d); else pass_cnt++;
            total_cnt++; if (m_first !== (i == 0)) $display("FAIL single_first[%0d] got=%b exp=%b", i, m_first, (i == 0)); else pass_cnt++;
            total_cnt++; if (m_last !== (i == 3)) $display("FAIL single_last[%0d] got=%b exp=%b", i, m_last, (i == 3)); else pass_cnt++;
            total_cnt++; if (s_ready !== (i == 3)) $display("FAIL single_s_ready[%0d] got=%b exp=%b", i, s_ready, (i == 3)); else pass_cnt++;
            advance();
        end
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_drained got=%b exp=0", m_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [UW-1:0] exp_d;
        m_ready = 1'b1;
        s_data = 32'hA3A2A1A0; s_num = 3'd4; s_last = 1'b0; s_valid = 1'b1;
        advance();
        s_data = 32'hB3B2B1B0; s_last = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 4) ? UW'(8'hA0 + i) : UW'(8'hB0 + i - 4);
            total_cnt++; if (m_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%b exp=1", i, m_valid); else pass_cnt++;
            total_cnt++; if (m_data !== exp_d) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, m_data, exp_d); else pass_cnt++;
            total_cnt++; if (m_last !== (i == 7)) $display("FAIL b2b_last[%0d] got=%b exp=%b", i, m_last, (i == 7)); else pass_cnt++;
            if (i < 4) begin
                total_cnt++; if (s_ready !== (i == 3)) $display("FAIL b2b_s_ready[%0d] got=%b exp=%b", i, s_ready, (i == 3)); else pass_cnt++;
            end
            advance();
            if (i == 3) s_valid = 1'b0;
        end
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", m_valid); else pass_cnt++;
    endtask

    task automatic test_partial_counts();
        logic [N*UW-1:0] wd [4];
        logic [NW-1:0]   wn [4];
        logic            wl [4];
        int              wexp [4];
        wd = '{32'hDDCCBBAA, 32'h87654321, 32'h1F2E3D4C, 32'h000000EE};
        wn = '{3'd2, 3'd0, 3'd6, 3'd1};
        wl = '{1'b0, 1'b0, 1'b0, 1'b1};
        wexp = '{2, 4, 4, 1};
        m_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            s_data = wd[w]; s_num = wn[w]; s_last = wl[w]; s_valid = 1'b1;
            advance();
            s_valid = 1'b0;
            #1;
            for (int j = 0; j < wexp[w]; j++) begin
                total_cnt++; if (m_valid !== 1'b1 || q.size() == 0) $display("FAIL part_valid[%0d.%0d] got=%b exp=1", w, j, m_valid);
                else begin
                    if (m_data !== q[0].d || m_first !== q[0].f || m_last !== q[0].l)
                        $display("FAIL part_unit[%0d.%0d] got=%h/%b/%b exp=%h/%b/%b", w, j, m_data, m_first, m_last, q[0].d, q[0].f, q[0].l);
                    else pass_cnt++;
                end
                advance();
            end
            total_cnt++; if (m_valid !== 1'b0) $display("FAIL part_len[%0d] got_valid=%b exp=0", w, m_valid); else pass_cnt++;
        end
        s_data = 32'h000000EE; s_num = 3'd1; s_last = 1'b1; s_valid = 1'b1;
        advance();
        s_valid = 1'b0;
        #1;
        total_cnt++; if ({m_first, m_last, s_ready} !== 3'b111) $display("FAIL one_unit first/last/ready got=%b exp=111", {m_first, m_last, s_ready}); else pass_cnt++;
        advance();
    endtask

    task automatic test_backpressure();
        int            words = 0;
        int            cyc   = 0;
        logic          acc;
        logic          pv = 1'b0;
        logic [UW+1:0] prev = '0;
        while ((words < 200 || q.size() != 0 || s_valid) && cyc < 5000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (!s_valid && words < 200 && $urandom_range(0, 3) != 0) begin
                s_data = $urandom(); s_num = NW'($urandom_range(0, 7));
                s_last = 1'($urandom_range(0, 1)); s_valid = 1'b1;
            end
            #1;
            total_cnt++; if (m_valid !== (q.size() != 0)) $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, m_valid, (q.size() != 0)); else pass_cnt++;
            total_cnt++; if (s_ready !== exp_ready()) $display("FAIL bp_s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_ready()); else pass_cnt++;
            if (q.size() != 0) begin
                total_cnt++;
                if (m_data !== q[0].d || m_first !== q[0].f || m_last !== q[0].l)
                    $display("FAIL bp_unit cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc, m_data, m_first, m_last, q[0].d, q[0].f, q[0].l);
                else pass_cnt++;
            end
            if (pv) begin
                total_cnt++; if ({m_data, m_first, m_last} !== prev) $display("FAIL bp_stall_stable cyc=%0d got=%h exp=%h", cyc, {m_data, m_first, m_last}, prev); else pass_cnt++;
            end
            pv   = m_valid && !m_ready;
            prev = {m_data, m_first, m_last};
            acc  = s_valid && exp_ready();
            advance();
            if (acc) begin
                s_valid = 1'b0;
                words++;
            end
            cyc++;
        end
        total_cnt++; if (cyc >= 5000) $display("FAIL bp_timeout words=%0d exp=200", words); else pass_cnt++;
    endtask

    task automatic test_cke_gating();
        logic [UW-1:0] prev_d;
        m_ready = 1'b1;
        s_data = 32'h13121110; s_num = 3'd4; s_last = 1'b0; s_valid = 1'b1;
        advance();
        s_data = 32'h23222120; s_last = 1'b1;
        prev_d = '0;
        for (int c = 0; c < 16; c++) begin
            logic acc;
            cke = !((c >= 1 && c <= 3) || (c >= 6 && c <= 8));
            #1;
            total_cnt++; if (m_valid !== (q.size() != 0)) $display("FAIL cke_valid[%0d] got=%b exp=%b", c, m_valid, (q.size() != 0)); else pass_cnt++;
            total_cnt++; if (s_ready !== exp_ready()) $display("FAIL cke_s_ready[%0d] got=%b exp=%b", c, s_ready, exp_ready()); else pass_cnt++;
            if (q.size() != 0) begin
                total_cnt++;
                if (m_data !== q[0].d || m_first !== q[0].f || m_last !== q[0].l)
                    $display("FAIL cke_unit[%0d] got=%h/%b/%b exp=%h/%b/%b", c, m_data, m_first, m_last, q[0].d, q[0].f, q[0].l);
                else pass_cnt++;
            end
            if (c == 2 || c == 3 || c == 7 || c == 8) begin
                total_cnt++; if (m_data !== prev_d) $display("FAIL cke_hold[%0d] got=%h exp=%h", c, m_data, prev_d); else pass_cnt++;
            end
            prev_d = m_data;
            acc = cke && s_valid && exp_ready();
            advance();
            if (acc) s_valid = 1'b0;
        end
        cke = 1'b1;
        total_cnt++; if (m_valid !== 1'b0 || s_valid !== 1'b0) $display("FAIL cke_resume_drained m_valid=%b s_valid=%b exp=0/0", m_valid, s_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        m_ready = 1'b1; cke = 1'b1;
        s_data = 32'h2B2A2928; s_num = 3'd4; s_last = 1'b1; s_valid = 1'b1;
        advance();
        s_valid = 1'b0;
        advance(); advance();
        reset_n = 1'b0;
        advance();
        reset_n = 1'b1;
        #1;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (m_data !== INIT) $display("FAIL rmid_m_data got=%h exp=%h", m_data, INIT); else pass_cnt++;
        total_cnt++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready got=%b exp=1", s_ready); else pass_cnt++;
        advance();
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_no_residue got=%b exp=0", m_valid); else pass_cnt++;
        s_data = 32'h3B3A3938; s_num = 3'd4; s_last = 1'b1; s_valid = 1'b1;
        advance();
        s_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== UW'(8'h38 + i) || m_first !== (i == 0))
                $display("FAIL rmid_next[%0d] got=%b/%h/%b exp=1/%h/%b", i, m_valid, m_data, m_first, UW'(8'h38 + i), (i == 0));
            else pass_cnt++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial_counts();
        test_backpressure();
        test_cke_gating();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
